// File: rtl/hamming_secded_pipe.sv
// Pipelined extended-Hamming (SEC-DED) decoder with a valid/ready handshake.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   in_valid/in_ready     input handshake for code_in (CODE_W bits)
//   out_valid/out_ready   output handshake for data_out, syndrome and status
//   status                00 clean, 01 corrected, 10 uncorrectable, 11 overall bit only
//   clr_cnt               synchronous clear of both error counters
//   corr_cnt/uncorr_cnt   saturating counts of corrected / uncorrectable outputs
module hamming_secded_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAR_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W+PAR_W:0]   code_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic [PAR_W-1:0]        syndrome,
  output logic [1:0]              status,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        corr_cnt,
  output logic [CNT_W-1:0]        uncorr_cnt
);

  localparam int unsigned HAM_W  = DATA_W + PAR_W;
  localparam int unsigned CODE_W = HAM_W + 1;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;
  localparam logic [1:0] ST_OVALL  = 2'b11;

  // Parameter sanity checks at elaboration
  if ((1 << PAR_W) < CODE_W) begin : g_bad_par_w
    $error("hamming_secded_pipe: PAR_W too small for DATA_W");
  end
  if (DATA_W < 4) begin : g_bad_data_w
    $error("hamming_secded_pipe: DATA_W must be at least 4");
  end

  // 1-based Hamming position of data bit j (non-power-of-two positions, ascending)
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // ---------------- stage 0: syndrome, overall parity, raw data ----------------
  logic [PAR_W-1:0]  syn_c;
  logic              par_c;
  logic [DATA_W-1:0] raw_c;

  // Syndrome bit k covers every position whose index has bit k set
  for (genvar k = 0; k < PAR_W; k++) begin : g_syn
    logic [HAM_W-1:0] terms;
    for (genvar i = 0; i < HAM_W; i++) begin : g_term
      if ((((i + 1) >> k) & 1) != 0) begin : g_on
        assign terms[i] = code_in[i];
      end else begin : g_off
        assign terms[i] = 1'b0;
      end
    end
    assign syn_c[k] = ^terms;
  end

  assign par_c = ^code_in;

  for (genvar j = 0; j < DATA_W; j++) begin : g_raw
    assign raw_c[j] = code_in[data_pos(j) - 1];
  end

  // ---------------- stage 1 registers ----------------
  // Only the data field of the codeword is kept; check bits are fully
  // summarised by the syndrome and parity.
  logic              v1;
  logic [DATA_W-1:0] data1;
  logic [PAR_W-1:0]  syn1;
  logic              par1;

  // ---------------- stage 1 -> 2: classification and correction ----------------
  logic [1:0]        st_c;
  logic [DATA_W-1:0] fixed_c;

  always_comb begin
    st_c = ST_CLEAN;
    if (syn1 == '0) begin
      st_c = par1 ? ST_OVALL : ST_CLEAN;
    end else if (!par1) begin
      st_c = ST_UNCORR;
    end else if (syn1 <= PAR_W'(HAM_W)) begin
      st_c = ST_CORR;
    end else begin
      st_c = ST_UNCORR;
    end
  end

  // Flip a data bit only when the syndrome points at that bit's position
  for (genvar j = 0; j < DATA_W; j++) begin : g_fix
    assign fixed_c[j] = data1[j] ^ ((st_c == ST_CORR) && (syn1 == PAR_W'(data_pos(j))));
  end

  // ---------------- pipeline control ----------------
  logic adv;
  logic out_fire;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_fire = out_valid && out_ready;

  // Both stages advance together; a stall freezes everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      data1     <= '0;
      syn1      <= '0;
      par1      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      syndrome  <= '0;
      status    <= ST_CLEAN;
    end else if (adv) begin
      v1        <= in_valid;
      data1     <= raw_c;
      syn1      <= syn_c;
      par1      <= par_c;
      out_valid <= v1;
      // Output fields only load with a real word so they stay 0 after reset
      if (v1) begin
        data_out <= fixed_c;
        syndrome <= syn1;
        status   <= st_c;
      end
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if ((status == ST_CORR) && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
      if ((status == ST_UNCORR) && (uncorr_cnt != '1)) begin
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Testbench for hamming_secded_pipe (DATA_W=8, PAR_W=4, CNT_W=2).
module tb_hamming_secded_pipe;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int CW = 2;
  localparam int N  = DW + PW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N:0]    code_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic [PW-1:0] syndrome;
  logic [1:0]    status;
  logic          clr_cnt;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  hamming_secded_pipe #(.DATA_W(DW), .PAR_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .status(status),
    .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    logic [1:0]    st;
  } exp_t;

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Place data in non-power-of-two positions, then choose check bits so the
  // XOR of the indices of all set positions is zero; top bit makes parity even.
  function automatic logic [N:0] ref_encode(input logic [DW-1:0] d);
    logic [N:0] c;
    int j;
    int s;
    c = '0;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        c[p-1] = d[j];
        j++;
      end
    end
    s = 0;
    for (int p = 1; p <= N; p++) if (c[p-1]) s = s ^ p;
    for (int k = 0; k < PW; k++) c[(1 << k) - 1] = s[k];
    c[N] = ^c[N-1:0];
    return c;
  endfunction

  function automatic exp_t ref_decode(input logic [N:0] code);
    exp_t e;
    logic [N:0] c;
    int s;
    int j;
    bit par;
    c = code;
    s = 0;
    for (int p = 1; p <= N; p++) if (c[p-1]) s = s ^ p;
    par = ^c;
    if (s == 0 && !par)      e.st = 2'b00;
    else if (s == 0)         e.st = 2'b11;
    else if (!par)           e.st = 2'b10;
    else if (s <= N) begin
      e.st = 2'b01;
      c[s-1] = ~c[s-1];
    end else                 e.st = 2'b10;
    e.syn = PW'(s);
    j = 0;
    e.data = '0;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        e.data[j] = c[p-1];
        j++;
      end
    end
    return e;
  endfunction

  function automatic logic [N:0] rand_code();
    logic [N:0] c;
    int a;
    int b;
    c = ref_encode(DW'($urandom));
    a = $urandom_range(0, N);
    case ($urandom_range(0, 4))
      0, 1: ;
      2: c[a] = ~c[a];
      3: begin
        b = (a + 1 + $urandom_range(0, N - 1)) % (N + 1);
        c[a] = ~c[a];
        c[b] = ~c[b];
      end
      default: c = (N+1)'($urandom);
    endcase
    return c;
  endfunction

  // ---------------- scoreboard monitor (negedge) ----------------
  exp_t          q[$];
  int            m_corr = 0;
  int            m_uncorr = 0;
  bit            after_rst = 1'b1;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [PW-1:0] prev_syn;
  logic [1:0]    prev_st;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_corr     = 0;
      m_uncorr   = 0;
      after_rst  = 1'b1;
      stall_prev = 1'b0;
    end else begin
      chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
      if (!out_valid) chk("in_ready_idle", 32'(in_ready), 32'd1);
      if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(data_out), 32'(prev_data));
        chk("stall_syn", 32'(syndrome), 32'(prev_syn));
        chk("stall_status", 32'(status), 32'(prev_st));
      end
      if (out_valid) after_rst = 1'b0;
      else if (after_rst) begin
        chk("rst_data_zero", 32'(data_out), 32'd0);
        chk("rst_syn_zero", 32'(syndrome), 32'd0);
        chk("rst_status_zero", 32'(status), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(data_out), 32'(e.data));
          chk("out_syndrome", 32'(syndrome), 32'(e.syn));
          chk("out_status", 32'(status), 32'(e.st));
          if (!clr_cnt) begin
            if (e.st == 2'b01 && m_corr < (1 << CW) - 1) m_corr++;
            if (e.st == 2'b10 && m_uncorr < (1 << CW) - 1) m_uncorr++;
          end
        end
      end
      if (clr_cnt) begin
        m_corr   = 0;
        m_uncorr = 0;
      end
      if (in_valid && in_ready) q.push_back(ref_decode(code_in));
      stall_prev = out_valid && !out_ready;
      prev_data  = data_out;
      prev_syn   = syndrome;
      prev_st    = status;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [N:0]    code;
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    logic [1:0]    st;
  } vec_t;

  vec_t       tbl[6];
  logic [N:0] bp_w[4];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  idx;
    bit  hs_pending;

    tbl[0] = '{13'h0A27, 8'hA5, 4'd0,  2'b00};
    tbl[1] = '{13'h0A07, 8'hA5, 4'd6,  2'b01};
    tbl[2] = '{13'h0A06, 8'hA1, 4'd7,  2'b10};
    tbl[3] = '{13'h1A27, 8'hA5, 4'd0,  2'b11};
    tbl[4] = '{13'h0A26, 8'hA5, 4'd1,  2'b01};
    tbl[5] = '{13'h0AAE, 8'hA5, 4'd13, 2'b10};

    rst_n = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_corr", 32'(corr_cnt), 32'd0);
    chk("reset_uncorr", 32'(uncorr_cnt), 32'd0);

    // Table: one word at a time, latency and decoded fields
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; code_in = tbl[v].code; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("tbl_data", 32'(data_out), 32'(tbl[v].data));
      chk("tbl_syn", 32'(syndrome), 32'(tbl[v].syn));
      chk("tbl_status", 32'(status), 32'(tbl[v].st));
    end
    @(posedge clk); #1;
    chk("tbl_corr_total", 32'(corr_cnt), 32'd2);
    chk("tbl_uncorr_total", 32'(uncorr_cnt), 32'd2);

    // Saturation: clear, then 5 corrected words back-to-back
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_corr", 32'(corr_cnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; code_in = 13'h0A07;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("corr_saturated", 32'(corr_cnt), 32'd3);

    // Clear in the same cycle as a corrected-word output handshake
    in_valid = 1'b1; code_in = 13'h0A07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_hs_valid", 32'(out_valid), 32'd1);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_priority", 32'(corr_cnt), 32'd0);

    // Backpressure: 4 words streamed, out_ready low for 3 cycles mid-stream
    bp_w[0] = 13'h0A07; bp_w[1] = ref_encode(8'h3C); bp_w[2] = 13'h0A06; bp_w[3] = 13'h1A27;
    idx = 0;
    hs_pending = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (hs_pending) idx++;
      out_ready = !(c >= 3 && c < 6);
      in_valid  = (idx < 4);
      if (idx < 4) code_in = bp_w[idx];
      #1 hs_pending = in_valid && in_ready;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_all_sent", 32'(idx), 32'd4);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Reset while a word is stalled at the output and another is in flight
    out_ready = 1'b0; in_valid = 1'b1; code_in = 13'h0A07;
    @(posedge clk); #1;
    code_in = 13'h0A06;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stalled_valid", 32'(out_valid), 32'd1);
    chk("stalled_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_corr", 32'(corr_cnt), 32'd0);
    chk("midrst_uncorr", 32'(uncorr_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("midrst_discarded", 32'(out_valid), 32'd0);

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      code_in   = rand_code();
      out_ready = ($urandom_range(0, 3) != 0);
      clr_cnt   = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rand_drained", 32'(q.size()), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_secded_pipe.md
Name: hamming_secded_pipe

Overview:
- Parametrised, pipelined extended-Hamming (SEC-DED) decoder with valid/ready handshake. It is the successor to the fixed 12-bit decoder.
- Each accepted codeword produces the corrected data, the syndrome and a 2-bit status code.
- Two saturating event counters track corrected and uncorrectable words.
- Sits on the receive side of the memory/link datapath, after the channel and before the data consumer.

Parameters:
DATA_W, 8, data bits per word (>=4).
PAR_W, 4, Hamming check bits; elaboration error unless 2**PAR_W >= DATA_W+PAR_W+1.
CNT_W, 16, width of each error counter.
(derived) CODE_W = DATA_W+PAR_W+1.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  code_in is valid.
in_ready  out  1  decoder accepts code_in this cycle.
code_in  in  CODE_W  received codeword.
out_valid  out  1  outputs valid.
out_ready  in  1  consumer accepts the output this cycle.
data_out  out  DATA_W  corrected data.
syndrome  out  PAR_W  computed syndrome.
status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 overall-parity bit error only.
clr_cnt  in  1  synchronous clear of both counters.
corr_cnt  out  CNT_W  saturating count of status 01.
uncorr_cnt  out  CNT_W  saturating count of status 10.

Behaviour:
- Codeword layout:
  - code_in[i] is Hamming position i+1 for i < DATA_W+PAR_W.
  - Check bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order, so data_out[0] is at position 3.
  - code_in[CODE_W-1] is the overall bit; the whole codeword has even parity.
- Syndrome: bit k = XOR of all positions whose index has bit k set. P = XOR of all CODE_W bits.
- Classification:
  - S==0, P==0 -> 00.
  - S!=0, P==1, S <= DATA_W+PAR_W -> 01; flip position S.
  - S==0, P==1 -> 11; data unchanged.
  - S!=0, P==0 -> 10; data passed uncorrected.
  - S > DATA_W+PAR_W, P==1 -> 10.
- Pipeline, 2 stages:
  - Stage 1 registers the codeword, S and P.
  - Stage 2 registers the corrected data, syndrome and status.
  - Latency from input handshake to out_valid is 2 cycles when there is no stall.
- Handshake:
  - A transfer occurs when valid && ready.
  - The whole pipeline advances when adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - A stage's valid bit loads from the previous stage when adv; a bubble propagates as valid=0.
  - While out_valid && !out_ready, all outputs stay stable and no stage changes.
  - Full throughput is 1 word/cycle with out_ready held high.
- Counters:
  - Each counter increments at the output handshake (out_valid && out_ready) when status is 01 or 10.
  - Counters saturate at all-ones.
  - clr_cnt has priority over a same-cycle increment; the counter becomes 0.
- Reset (rst_n==0 at a clock edge):
  - All valid bits, data_out, syndrome, status and both counters go to 0.
  - in_ready reads 1 after reset.
  - In-flight words are discarded, including any stalled word (mid-operation reset).
- Only valid bits gate behaviour. Data registers may be written while invalid, but outputs must read 0 after reset until the first valid word.

Test Plan:
- Clean word (DATA_W=8): code_in=13'h0A27 -> 2 cycles later data_out=8'hA5, syndrome=0, status=00; counters unchanged.
- Single data error: 13'h0A07 (position 6 flipped) -> data_out=8'hA5, syndrome=4'd6, status=01; corr_cnt +1 after handshake.
- Double error: 13'h0A06 -> syndrome=4'd7, status=10, data_out=8'hA1 (uncorrected); uncorr_cnt +1.
- Overall-bit error: 13'h1A27 -> syndrome=0, status=11, data_out=8'hA5; no counter change.
- Backpressure:
  - Stream 4 words back-to-back, hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 during the stall, output held stable, no word lost or duplicated, order preserved.
  - Then reset while stalled -> out_valid=0 and counters 0 on the next cycle.
- Counter edges (CNT_W=2):
  - 5 corrected words -> corr_cnt saturates at 3.
  - clr_cnt in the same cycle as a corrected-word handshake -> corr_cnt=0.
